ntt_stage_sequencer: RTL



---
 rtl/ntt_pkg.sv | 43 ++++
 rtl/ntt_addr_gen.sv | 45 ++++
 rtl/ntt_stage_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared types and constants for the NTT stage sequencer:
//                FSM state encoding, default address width, router log-field
//                width and the butterfly bit-position helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    // Default core memory address width.
    localparam int NTT_ADDR_W = 9;

    // Width of the router log_m / log_t configuration fields.
    localparam int NTT_LOG_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

    // Position at which the butterfly partner bit is inserted into k.
    // log_t = 0 (last stage) pairs neighbours, so the bit goes at 0; otherwise
    // it sits just below log_t, clamped to the top address bit.
    function automatic int ntt_bit_pos(input logic [NTT_LOG_W-1:0] log_t,
                                       input int                   addr_w);
        int pos;
        if (log_t == '0) begin
            pos = 0;
        end else begin
            pos = int'(log_t) - 1;
            if (pos > addr_w - 1) begin
                pos = addr_w - 1;
            end
        end
        return pos;
    endfunction

endpackage : ntt_pkg
`default_nettype wire

// File: rtl/ntt_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_addr_gen
//  Description : Butterfly address pair generator. Takes the pair index k and
//                a bit position b and inserts a 0 (address_0) or a 1
//                (address_1) at position b, shifting the upper bits of k up.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_addr_gen #(
    parameter int ADDR_W = 9,
    parameter int KW     = 4,
    parameter int BW     = 4
) (
    input  logic [KW-1:0]     k_i,
    input  logic [BW-1:0]     b_i,
    output logic [ADDR_W-1:0] address_0_o,
    output logic [ADDR_W-1:0] address_1_o
);

    logic [ADDR_W-1:0] w_k_ext;
    logic [ADDR_W-1:0] w_k_sh;

    // Bits below b pass straight through, bit b is the partner select, bits
    // above b come from k shifted up by one; anything past ADDR_W is dropped.
    always_comb begin
        w_k_ext     = ADDR_W'(k_i);
        w_k_sh      = w_k_ext << 1;
        address_0_o = '0;
        address_1_o = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (i < int'(b_i)) begin
                address_0_o[i] = w_k_ext[i];
                address_1_o[i] = w_k_ext[i];
            end else if (i == int'(b_i)) begin
                address_0_o[i] = 1'b0;
                address_1_o[i] = 1'b1;
            end else begin
                address_0_o[i] = w_k_sh[i];
                address_1_o[i] = w_k_sh[i];
            end
        end
    end

endmodule : ntt_addr_gen
`default_nettype wire

// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_stage_sequencer
//  Description : Walks an NTT transform stage by stage. Each stage issues
//                2^LOG_PAIRS butterfly address pairs to the router (holding
//                on stall), then idles DRAIN_CYCLES cycles for writeback
//                before the next stage. loop_valid is issue delayed by the
//                router latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int LOG_CORE_COUNT = 5,
    parameter int ADDR_W         = NTT_ADDR_W,
    parameter int LOG_PAIRS      = 4,
    parameter int ROUTER_LAT     = 1,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           num_stages,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           stage,
    output logic [NTT_LOG_W-1:0] log_m,
    output logic [NTT_LOG_W-1:0] log_t,
    output logic [ADDR_W-1:0]    address_0,
    output logic [ADDR_W-1:0]    address_1,
    output logic                 issue,
    output logic                 loop_valid
);

    // Pair counter width; a single-pair stage still needs one bit of storage.
    localparam int KW         = (LOG_PAIRS > 0) ? LOG_PAIRS : 1;
    // Bit-position width, wide enough for ADDR_W-1.
    localparam int BW         = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    // Drain counter width, wide enough for DRAIN_CYCLES-1.
    localparam int DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int LAT        = (ROUTER_LAT > 0) ? ROUTER_LAT : 1;

    localparam logic [KW-1:0]  K_LAST = KW'((1 << LOG_PAIRS) - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_LAST);

    // Reject configurations the address generator cannot represent.
    if (LOG_PAIRS < 0 || LOG_PAIRS > ADDR_W - 1 || LOG_CORE_COUNT < 0
        || ROUTER_LAT < 0 || DRAIN_CYCLES < 0) begin : g_bad_cfg
        $error("ntt_stage_sequencer: illegal parameter combination");
    end

    ntt_state_e           state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [3:0]           s_q, s_d;
    logic [3:0]           n_q, n_d;
    logic [NTT_LOG_W-1:0] log_t_q, log_t_d;
    logic [DCW-1:0]       dcnt_q, dcnt_d;

    logic                 w_last_stage;
    logic [BW-1:0]        w_b;
    logic [ADDR_W-1:0]    w_addr_0;
    logic [ADDR_W-1:0]    w_addr_1;

    assign w_last_stage = (s_q == (n_q - 4'd1));

    // Sequencer state and counters; reset abandons any transform in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            n_q     <= '0;
            log_t_q <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            n_q     <= n_d;
            log_t_q <= log_t_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state logic: start only in IDLE, stall freezes RUN, DRAIN ignores
    // stall, the final stage's drain leads to a single DONE cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        n_d     = n_q;
        log_t_d = log_t_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_stages != 4'd0) begin
                        n_d     = num_stages;
                        s_d     = '0;
                        k_d     = '0;
                        dcnt_d  = '0;
                        log_t_d = NTT_LOG_W'(num_stages - 4'd1);
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (k_q == K_LAST) begin
                        k_d    = '0;
                        dcnt_d = '0;
                        if (DRAIN_CYCLES > 0) begin
                            state_d = ST_DRAIN;
                        end else if (w_last_stage) begin
                            state_d = ST_DONE;
                        end else begin
                            s_d     = s_q + 4'd1;
                            log_t_d = log_t_q - NTT_LOG_W'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    dcnt_d = '0;
                    if (w_last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + 4'd1;
                        log_t_d = log_t_q - NTT_LOG_W'(1);
                        k_d     = '0;
                        state_d = ST_RUN;
                    end
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_b = BW'(ntt_bit_pos(log_t_q, ADDR_W));

    ntt_addr_gen #(
        .ADDR_W (ADDR_W),
        .KW     (KW),
        .BW     (BW)
    ) u_addr_gen (
        .k_i         (k_q),
        .b_i         (w_b),
        .address_0_o (w_addr_0),
        .address_1_o (w_addr_1)
    );

    // Addresses are only meaningful while issuing (or stalled) in RUN.
    assign address_0 = (state_q == ST_RUN) ? w_addr_0 : '0;
    assign address_1 = (state_q == ST_RUN) ? w_addr_1 : '0;
    assign issue     = (state_q == ST_RUN) && !stall;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign stage     = s_q;
    assign log_m     = NTT_LOG_W'(s_q);
    assign log_t     = log_t_q;

    if (ROUTER_LAT == 0) begin : g_lat_zero
        assign loop_valid = issue;
    end else begin : g_lat_pipe
        logic [LAT-1:0] lv_q;

        // Free-running issue delay line; it never stalls with the sequencer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lv_q <= '0;
            end else begin
                lv_q[0] <= issue;
                for (int i = 1; i < LAT; i++) begin
                    lv_q[i] <= lv_q[i-1];
                end
            end
        end

        assign loop_valid = lv_q[LAT-1];
    end

endmodule : ntt_stage_sequencer
`default_nettype wire
